// File: rtl/serial_frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// State encoding is fixed so the frame state can be decoded by downstream logic.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_N = 8;

endpackage

// File: rtl/tx_bit_counter.sv
// Frame bit counter: clears on acceptance, advances once per data bit and
// saturates on the last bit so it never wraps inside a frame.
module tx_bit_counter #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CW'(N - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter feeding a shift register stage.
// Define SERIAL_FRAME_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         msb_first,
  input  logic         valid,
  output logic         ready,
  output logic         ser_out,
  output logic         shift_en,
  output logic         direction,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = $clog2(N);

  state_e        state_q, state_d;
  logic [N-1:0]  buf_q, buf_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          cnt_clr;
  logic          cnt_inc;
  logic [N-1:0]  buf_rev;
  logic [N-1:0]  ordered;
  logic          data_bit;

  // Mirrored copy lets MSB-first frames use the same ascending counter index.
  for (genvar gi = 0; gi < N; gi++) begin : g_rev
    assign buf_rev[gi] = buf_q[N-1-gi];
  end

  assign ordered  = dir_q ? buf_rev : buf_q;
  assign data_bit = ordered[cnt];

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = ^buf_q;
`endif

  tx_bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  // Gated by reset so the block never advertises acceptance during reset.
  assign ready     = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign direction = dir_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    dir_d      = dir_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    ser_out    = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          buf_d   = data_in;
          dir_d   = msb_first;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        ser_out  = data_bit;
        cnt_inc  = 1'b1;
        if (cnt_last) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        shift_en = 1'b1;
        ser_out  = parity_bit;
        state_d  = DONE;
      end
`endif
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (N=8); honours SERIAL_FRAME_TX_PARITY_EN.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       msb_first;
  logic       valid;
  logic       ready;
  logic       ser_out;
  logic       shift_en;
  logic       direction;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  serial_frame_tx #(.N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .msb_first  (msb_first),
    .valid      (valid),
    .ready      (ready),
    .ser_out    (ser_out),
    .shift_en   (shift_en),
    .direction  (direction),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // seq holds the expected serial bits in time order, first bit at seq[7].
  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    chk("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  // Checks the N data bits (and parity when built in) of a frame already accepted,
  // starting in the cycle right after the accepting edge.
  task automatic check_frame(input logic [7:0] seq, input logic msb, input logic par,
                             input int first_bit);
    for (int i = first_bit; i < 8; i++) begin
      chk("ser_out",    {31'd0, ser_out},    {31'd0, seq[7-i]});
      chk("shift_en",   {31'd0, shift_en},   32'd1);
      chk("direction",  {31'd0, direction},  {31'd0, msb});
      chk("busy",       {31'd0, busy},       32'd1);
      chk("ready_low",  {31'd0, ready},      32'd0);
      chk("no_done",    {31'd0, frame_done}, 32'd0);
      tick();
    end
    if (PAR == 1) begin
      chk("parity_bit", {31'd0, ser_out},  {31'd0, par});
      chk("parity_en",  {31'd0, shift_en}, 32'd1);
      chk("parity_nodone", {31'd0, frame_done}, 32'd0);
      tick();
    end
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    chk("done_en",    {31'd0, shift_en},   32'd0);
    chk("done_ser",   {31'd0, ser_out},    32'd0);
    chk("done_dir",   {31'd0, direction},  {31'd0, msb});
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, msb: 1'b1, seq: 8'b10100101, par: 1'b0};
    vecs[1] = '{data: 8'hA5, msb: 1'b0, seq: 8'b10100101, par: 1'b0};
    vecs[2] = '{data: 8'h01, msb: 1'b1, seq: 8'b00000001, par: 1'b1};
    vecs[3] = '{data: 8'h01, msb: 1'b0, seq: 8'b10000000, par: 1'b1};
    vecs[4] = '{data: 8'hC8, msb: 1'b0, seq: 8'b00010011, par: 1'b1};
    vecs[5] = '{data: 8'h07, msb: 1'b1, seq: 8'b00000111, par: 1'b1};

    reset     = 1'b1;
    data_in   = 8'h00;
    msb_first = 1'b0;
    valid     = 1'b0;

    // Reset held for two cycles.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", {31'd0, ready},      32'd0);
      chk("rst_ser",   {31'd0, ser_out},    32'd0);
      chk("rst_en",    {31'd0, shift_en},   32'd0);
      chk("rst_dir",   {31'd0, direction},  32'd0);
      chk("rst_busy",  {31'd0, busy},       32'd0);
      chk("rst_done",  {31'd0, frame_done}, 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, ready}, 32'd1);
    $display("reset sequence checked");

    // Single-word frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      wait_ready();
      data_in   = vecs[v].data;
      msb_first = vecs[v].msb;
      valid     = 1'b1;
      tick();
      valid     = 1'b0;
      data_in   = ~vecs[v].data;
      msb_first = ~vecs[v].msb;
      check_frame(vecs[v].seq, vecs[v].msb, vecs[v].par, 0);
      tick();
      chk("done_once",   {31'd0, frame_done}, 32'd0);
      chk("ready_back",  {31'd0, ready},      32'd1);
      chk("idle_busy",   {31'd0, busy},       32'd0);
      $display("vec %0d data=%02h msb_first=%0d checked", v, vecs[v].data, vecs[v].msb);
    end

    // Back-to-back: valid held high, second word must wait for ready.
    wait_ready();
    data_in   = 8'h0F;
    msb_first = 1'b1;
    valid     = 1'b1;
    tick();
    data_in   = 8'hF0;
    check_frame(8'b00001111, 1'b1, 1'b0, 0);
    tick();
    chk("b2b_ready", {31'd0, ready}, 32'd1);
    tick();
    valid   = 1'b0;
    data_in = 8'h00;
    check_frame(8'b11110000, 1'b1, 1'b0, 0);
    tick();
    chk("b2b_ready2", {31'd0, ready}, 32'd1);
    $display("back-to-back 0F then F0 checked");

    // Reset during the 4th data bit, with valid also high: reset wins.
    wait_ready();
    data_in   = 8'hB3;
    msb_first = 1'b1;
    valid     = 1'b1;
    tick();
    valid     = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_bit4", {31'd0, ser_out}, 32'd1);
    reset   = 1'b1;
    valid   = 1'b1;
    data_in = 8'hFF;
    tick();
    chk("mid_en",    {31'd0, shift_en},   32'd0);
    chk("mid_busy",  {31'd0, busy},       32'd0);
    chk("mid_done",  {31'd0, frame_done}, 32'd0);
    chk("mid_ready", {31'd0, ready},      32'd0);
    chk("mid_dir",   {31'd0, direction},  32'd0);
    reset = 1'b0;
    valid = 1'b0;
    tick();
    chk("mid_ready_after", {31'd0, ready}, 32'd1);
    chk("mid_not_accepted", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 12; c++) begin
      chk("mid_no_done", {31'd0, frame_done}, 32'd0);
      tick();
    end
    $display("mid-frame reset checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
